hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage RSA pipeline CPU (F, D, E, M, W). It generates the stall, flush and forwarding selects for the pipeline registers. It sequences multi-cycle data-memory accesses and branch redirects with an internal FSM, and keeps saturating stall and flush performance counters. It sits beside the control unit and drives the enables and clears of every pipeline register.

Parameters:
BR_FLUSH_CYCLES, 1, extra cycles FlushD stays high after a taken branch (instruction memory fetch latency); range 0..3
MEM_TIMEOUT, 64, maximum cycles spent in MEM_WAIT before forced release; range 2..255
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
RA1D, RA2D  in  4 each  source registers of the instruction in D
RA1E, RA2E  in  4 each  source registers of the instruction in E
WA3E, WA3M, WA3W  in  4 each  destination registers in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables in E/M/W
MemtoRegE  in  1  the instruction in E is a load
MemAccessM  in  1  LDR/STR is in M
MemReadyM  in  1  data memory completes the access this cycle
BranchTakenE  in  1  branch resolved taken in E
StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register
FlushD, FlushE, FlushW  out  1 each  clear the pipeline register to a bubble
ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 W result, 10 M ALU result
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  count of cycles with StallF=1, saturating
flush_cnt  out  CNT_W  count of taken-branch redirects, saturating

Behaviour:
- Reset (async, rst_n=0): state RUN, every stall/flush output 0, Forward* 00, mem_err 0, both counters 0, flush counter 0.
- Forwarding (combinational, active in every state):
  - ForwardAE=10 if RegWriteM & WA3M==RA1E.
  - Otherwise ForwardAE=01 if RegWriteW & WA3W==RA1E.
  - Otherwise ForwardAE=00.
  - M has priority over W. R15 (4'hF) is never forwarded; it always selects 00. ForwardBE is identical, using RA2E.
- FSM states: RUN, MEM_WAIT, BR_FLUSH.
- RUN, evaluated in priority order:
  1. MemAccessM & !MemReadyM: StallF, StallD, StallE, StallM=1 and FlushW=1 in the same cycle (combinational). Go to MEM_WAIT, wait counter=1.
  2. BranchTakenE: FlushD=1 and FlushE=1 this cycle, flush_cnt+1. If BR_FLUSH_CYCLES>0, go to BR_FLUSH with counter=BR_FLUSH_CYCLES.
  3. Load-use (MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D)): StallF=1, StallD=1, FlushE=1 for that cycle. Stay in RUN. The hazard clears the next cycle because the load advances.
- MEM_WAIT:
  - StallF/D/E/M=1 and FlushW=1 while MemReadyM=0. The wait counter increments each cycle.
  - MemReadyM=1: all stalls drop combinationally that cycle, go to RUN.
  - Wait counter reaches MEM_TIMEOUT: set mem_err (sticky until reset), release the stalls, go to RUN.
  - BranchTakenE is ignored while in MEM_WAIT. E is frozen, so the branch is acted on in the first RUN cycle after release.
- BR_FLUSH:
  - FlushD=1 each cycle, counter decrements. Go to RUN when it reaches 0 (exactly BR_FLUSH_CYCLES cycles).
  - A load-use hazard is suppressed here because D is being flushed.
  - A memory miss (MemAccessM & !MemReadyM) takes priority: go to MEM_WAIT, and the remaining flush cycles are discarded.
  - A new BranchTakenE reloads the counter and increments flush_cnt.
- Counters: stall_cnt increments on every cycle with StallF=1. Both counters saturate at all-ones and never wrap.
- Simultaneous events: memory miss > branch > load-use. A lower-priority condition that is masked is not latched. It is re-evaluated while its inputs persist.
- rst_n asserted mid-MEM_WAIT or mid-BR_FLUSH: immediate return to RUN with every output at its reset value.

Test Plan:
- ADD R1,R2,R3 followed by SUB R4,R1,R5 (WA3M=1, RA1E=1, RegWriteM=1) -> ForwardAE=10. One cycle later (W match only) -> ForwardAE=01. With RA1E=15 -> ForwardAE=00.
- LDR R2 in E (MemtoRegE=1, WA3E=2) and RA2D=2 -> StallF=StallD=FlushE=1 for exactly 1 cycle, stall_cnt=1.
- MemAccessM=1 with MemReadyM low for 5 cycles -> StallF..StallM=1 and FlushW=1 for 5 cycles, release on the ready cycle, stall_cnt=5.
- BranchTakenE=1 with BR_FLUSH_CYCLES=1 -> FlushD=FlushE=1 in cycle 0, FlushD=1 in cycle 1, RUN in cycle 2, flush_cnt=1.
- BranchTakenE and a memory miss in the same cycle -> memory stall only. Flush happens on the first cycle after MemReadyM.
- MemReadyM held low for MEM_TIMEOUT=64 cycles -> release at cycle 64, mem_err=1 until rst_n=0, then mem_err=0 and counters=0.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: operand forwarding,
// load-use stalls, multi-cycle data-memory stalls with timeout, and branch flushes.
module hazard_controller #(
  parameter int unsigned BR_FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StBrFlush} state_e;

  state_e           r_state, w_state_nxt;
  logic [7:0]       r_wait_cnt, w_wait_nxt;
  logic [1:0]       r_br_cnt, w_br_nxt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_miss, w_load_use, w_stall_all, w_lu_stall, w_flush_d, w_flush_e;
  logic w_err_set, w_flush_inc;
  logic [1:0] w_fwd_a, w_fwd_b;

  // M stage wins over W; R15 is the PC and is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic wr_m,
                                         input logic [3:0] wa_m, input logic wr_w,
                                         input logic [3:0] wa_w);
    if (ra == 4'hF)                return 2'b00;
    else if (wr_m && (wa_m == ra)) return 2'b10;
    else if (wr_w && (wa_w == ra)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign w_miss     = MemAccessM & ~MemReadyM;
  assign w_load_use = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // Forwarding selects, independent of the FSM state.
  always_comb begin
    w_fwd_a = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    w_fwd_b = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  // Next-state and stall/flush decode; priority is memory miss > branch > load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_br_nxt    = r_br_cnt;
    w_stall_all = 1'b0;
    w_lu_stall  = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_err_set   = 1'b0;
    w_flush_inc = 1'b0;
    unique case (r_state)
      StRun: begin
        if (w_miss) begin
          w_stall_all = 1'b1;
          w_state_nxt = StMemWait;
          w_wait_nxt  = 8'd1;
        end else if (BranchTakenE) begin
          w_flush_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_flush_inc = 1'b1;
          if (BR_FLUSH_CYCLES > 0) begin
            w_state_nxt = StBrFlush;
            w_br_nxt    = 2'(BR_FLUSH_CYCLES);
          end
        end else if (w_load_use) begin
          w_lu_stall = 1'b1;
          w_flush_e  = 1'b1;
        end
      end
      StMemWait: begin
        // E is frozen here, so a pending branch is picked up after release.
        if (MemReadyM) begin
          w_state_nxt = StRun;
        end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
          w_err_set   = 1'b1;
          w_state_nxt = StRun;
        end else begin
          w_stall_all = 1'b1;
          w_wait_nxt  = r_wait_cnt + 8'd1;
        end
      end
      StBrFlush: begin
        // Load-use is ignored: the dependent instruction in D is being flushed.
        if (w_miss) begin
          w_stall_all = 1'b1;
          w_state_nxt = StMemWait;
          w_wait_nxt  = 8'd1;
        end else if (BranchTakenE) begin
          w_flush_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_flush_inc = 1'b1;
          w_br_nxt    = 2'(BR_FLUSH_CYCLES);
        end else begin
          w_flush_d = 1'b1;
          w_br_nxt  = r_br_cnt - 2'd1;
          if (r_br_cnt <= 2'd1) w_state_nxt = StRun;
        end
      end
      default: w_state_nxt = StRun;
    endcase
  end

  // Outputs are forced to their reset values while reset is asserted.
  always_comb begin
    StallF    = rst_n & (w_stall_all | w_lu_stall);
    StallD    = rst_n & (w_stall_all | w_lu_stall);
    StallE    = rst_n & w_stall_all;
    StallM    = rst_n & w_stall_all;
    FlushW    = rst_n & w_stall_all;
    FlushD    = rst_n & w_flush_d;
    FlushE    = rst_n & w_flush_e;
    ForwardAE = rst_n ? w_fwd_a : 2'b00;
    ForwardBE = rst_n ? w_fwd_b : 2'b00;
    mem_err   = r_mem_err;
    stall_cnt = r_stall_cnt;
    flush_cnt = r_flush_cnt;
  end

  // State, sequencing counters, sticky error and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_wait_cnt  <= 8'd0;
      r_br_cnt    <= 2'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_br_cnt   <= w_br_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with default parameters.
module tb_hazard_controller;

  logic        clk;
  logic        rst_n;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemAccessM, MemReadyM;
  logic        BranchTakenE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] CtlNone = 7'b0000000;
  localparam logic [6:0] CtlMem  = 7'b1111001;
  localparam logic [6:0] CtlLu   = 7'b1100010;
  localparam logic [6:0] CtlBr   = 7'b0000110;
  localparam logic [6:0] CtlBrf  = 7'b0000100;

  logic [6:0] ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_controller #(
    .BR_FLUSH_CYCLES(1),
    .MEM_TIMEOUT    (64),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RA1D        (RA1D),
    .RA2D        (RA2D),
    .RA1E        (RA1E),
    .RA2E        (RA2E),
    .WA3E        (WA3E),
    .WA3M        (WA3M),
    .WA3W        (WA3W),
    .RegWriteE   (RegWriteE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .MemAccessM  (MemAccessM),
    .MemReadyM   (MemReadyM),
    .BranchTakenE(BranchTakenE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemAccessM = 1'b0; MemReadyM = 1'b0; BranchTakenE = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(CtlNone));
    chk("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    chk("reset_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Forwarding: M over W, W only, R15 excluded, B operand.
    RA1E = 4'd1; WA3M = 4'd1; RegWriteM = 1'b1; WA3W = 4'd1; RegWriteW = 1'b1;
    #1 chk("fwdA_M", 32'(ForwardAE), 32'd2);
    RegWriteM = 1'b0;
    #1 chk("fwdA_W", 32'(ForwardAE), 32'd1);
    RA1E = 4'hF; WA3M = 4'hF; RegWriteM = 1'b1; WA3W = 4'hF;
    #1 chk("fwdA_R15", 32'(ForwardAE), 32'd0);
    RA2E = 4'd3; WA3W = 4'd3; RegWriteM = 1'b0;
    #1 chk("fwdB_W", 32'(ForwardBE), 32'd1);
    chk("fwd_noctl", 32'(ctl), 32'(CtlNone));
    idle();
    step();

    // Load-use: LDR R2 in E, R2 read in D.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd7;
    #1 chk("lu_ctl", 32'(ctl), 32'(CtlLu));
    exp_stall += 1;
    step();
    idle();
    #1 chk("lu_clear", 32'(ctl), 32'(CtlNone));
    chk("lu_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Memory access pending for five cycles, ready on the sixth.
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("mem_stall_%0d", i), 32'(ctl), 32'(CtlMem));
      exp_stall += 1;
      step();
    end
    MemReadyM = 1'b1;
    #1 chk("mem_release", 32'(ctl), 32'(CtlNone));
    step();
    idle();
    #1 chk("mem_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("mem_idle", 32'(ctl), 32'(CtlNone));

    // Taken branch, one extra FlushD cycle; load-use masked during it.
    BranchTakenE = 1'b1;
    #1 chk("br_c0", 32'(ctl), 32'(CtlBr));
    exp_flush += 1;
    step();
    BranchTakenE = 1'b0;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    #1 chk("br_c1_lu_masked", 32'(ctl), 32'(CtlBrf));
    step();
    #1 chk("br_c2_lu", 32'(ctl), 32'(CtlLu));
    exp_stall += 1;
    step();
    idle();
    #1 chk("br_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    chk("br_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Branch together with a memory miss: memory first, branch after release.
    BranchTakenE = 1'b1; MemAccessM = 1'b1; MemReadyM = 1'b0;
    #1 chk("brmem_c0", 32'(ctl), 32'(CtlMem));
    exp_stall += 1;
    step();
    #1 chk("brmem_c1", 32'(ctl), 32'(CtlMem));
    exp_stall += 1;
    step();
    MemReadyM = 1'b1;
    #1 chk("brmem_ready", 32'(ctl), 32'(CtlNone));
    step();
    MemAccessM = 1'b0; MemReadyM = 1'b0;
    #1 chk("brmem_branch", 32'(ctl), 32'(CtlBr));
    exp_flush += 1;
    step();
    BranchTakenE = 1'b0;
    #1 chk("brmem_brf", 32'(ctl), 32'(CtlBrf));
    chk("brmem_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    step();
    #1 chk("brmem_run", 32'(ctl), 32'(CtlNone));

    // Branch arriving during the flush window reloads it.
    BranchTakenE = 1'b1;
    #1 chk("reload_c0", 32'(ctl), 32'(CtlBr));
    exp_flush += 1;
    step();
    #1 chk("reload_c1", 32'(ctl), 32'(CtlBr));
    exp_flush += 1;
    step();
    BranchTakenE = 1'b0;
    #1 chk("reload_c2", 32'(ctl), 32'(CtlBrf));
    step();
    #1 chk("reload_run", 32'(ctl), 32'(CtlNone));
    chk("reload_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // Memory never ready: forced release after 64 stalled cycles.
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (ctl !== CtlMem) chk($sformatf("to_stall_%0d", i), 32'(ctl), 32'(CtlMem));
      exp_stall += 1;
      step();
    end
    #1 chk("to_release", 32'(ctl), 32'(CtlNone));
    chk("to_err_before", 32'(mem_err), 32'd0);
    MemAccessM = 1'b0;
    step();
    #1 chk("to_err_set", 32'(mem_err), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    repeat (3) step();
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // Reset while in MEM_WAIT.
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    step();
    rst_n = 1'b0;
    #1 chk("rst_mid_ctl", 32'(ctl), 32'(CtlNone));
    chk("rst_mid_err", 32'(mem_err), 32'd0);
    chk("rst_mid_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    #1 chk("rst_run_ctl", 32'(ctl), 32'(CtlNone));
    step();
    chk("rst_run_cnt", 32'(stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
